// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the pipeline memory stage and the SRAM-facing blocks.
//   sram_state_t  : controller FSM state encoding
//   BASE_ADDR_DEF : byte address that maps to SRAM word 0
//   SRAM_DW       : external SRAM data width (bits)
//   word_offset() : byte address -> 32-bit word offset from a base
// -----------------------------------------------------------------------------
package arm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } sram_state_t;

   localparam int unsigned BASE_ADDR_DEF = 1024;
   localparam int unsigned SRAM_DW       = 16;

   // Word offset of a byte address relative to base; byte-lane bits dropped.
   function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      logic [31:0] diff;
      diff = addr - base;
      return diff >> 2;
   endfunction

endpackage

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Loadable down-counter. Load with N-1 on entry to a timed phase; `done` is
// high in the phase's last cycle (count reached zero while enabled).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : value to load
//   en         : counting enabled / phase active
//   done       : terminal cycle of the phase
// -----------------------------------------------------------------------------
module wait_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = en && (count == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sram_ctrl
// Memory-stage controller serving 32-bit loads/stores from a 16-bit
// asynchronous SRAM as two halfword accesses (lo half first), each held on
// the bus for WAIT_CYCLES cycles.
//
// Handshake: a request (mem_r_en | mem_w_en) is accepted in IDLE. `ready` is
// combinational: low from the request cycle until the access completes, high
// for exactly one cycle in DONE, and high in IDLE when nothing is requested.
// The upstream pipeline is frozen while `ready` is low, so request inputs are
// only looked at in IDLE; the request still present in DONE is not restarted.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   mem_r_en, mem_w_en : load / store request (both -> store)
//   alu_res            : byte address
//   val_rm             : store data
//   ready              : no access pending (low = freeze pipeline)
//   read_data          : last loaded word
//   sram_addr          : halfword address {word index, half}
//   sram_dq_out        : write data, sram_dq_oe : data-bus output enable
//   sram_dq_in         : read data, sram_we_n : write enable (active-low)
//   dbg_state          : current FSM state
// -----------------------------------------------------------------------------
module mem_sram_ctrl
   import arm_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        alu_res,
   input  logic [31:0]        val_rm,
   output logic               ready,
   output logic [31:0]        read_data,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n,
   output sram_state_t        dbg_state
);

   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

   sram_state_t          state;
   logic                 req;
   logic [31:0]          word_off;
   logic [SRAM_AW-2:0]   word_idx;
   logic [SRAM_DW-1:0]   data_hi_q;
   logic                 timed;
   logic                 cnt_load;
   logic                 cnt_done;
   logic                 unused_word_bits;

   assign req      = mem_r_en | mem_w_en;
   assign word_off = word_offset(alu_res, 32'(BASE_ADDR));
   // Word index wraps to the SRAM size; higher offset bits are discarded.
   assign word_idx = word_off[SRAM_AW-2:0];
   assign unused_word_bits = ^word_off[31:SRAM_AW-1];

   assign timed = (state == RD_LO) || (state == RD_HI) ||
                  (state == WR_LO) || (state == WR_HI);

   // Counter restarts on entry to every timed state.
   assign cnt_load = ((state == IDLE) && req) ||
                     (((state == RD_LO) || (state == WR_LO)) && cnt_done);

   wait_counter #(.W(CW)) u_wait (
      .clk      (clk),
      .rst_n    (rst),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .en       (timed),
      .done     (cnt_done)
   );

   assign ready     = ((state == IDLE) && !req) || (state == DONE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         data_hi_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  sram_addr <= {word_idx, 1'b0};
                  if (mem_w_en) begin
                     state       <= WR_LO;
                     sram_we_n   <= 1'b0;
                     sram_dq_oe  <= 1'b1;
                     sram_dq_out <= val_rm[15:0];
                     data_hi_q   <= val_rm[31:16];
                  end else begin
                     state <= RD_LO;
                  end
               end
            end
            RD_LO: begin
               if (cnt_done) begin
                  read_data[15:0] <= sram_dq_in;
                  sram_addr       <= {sram_addr[SRAM_AW-1:1], 1'b1};
                  state           <= RD_HI;
               end
            end
            RD_HI: begin
               if (cnt_done) begin
                  read_data[31:16] <= sram_dq_in;
                  state            <= DONE;
               end
            end
            WR_LO: begin
               // we_n stays low across the half switch; address and data
               // move together on this edge.
               if (cnt_done) begin
                  sram_addr   <= {sram_addr[SRAM_AW-1:1], 1'b1};
                  sram_dq_out <= data_hi_q;
                  state       <= WR_HI;
               end
            end
            WR_HI: begin
               if (cnt_done) begin
                  sram_we_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_sram_ctrl
// Directed bench for mem_sram_ctrl: a WAIT_CYCLES=2 instance against a small
// SRAM array model, plus WAIT_CYCLES=1 and =4 instances for back-to-back loads.
// -----------------------------------------------------------------------------
module tb_mem_sram_ctrl;
   import arm_pkg::*;

   localparam int WC = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
   logic        mem_r_en, mem_w_en;
   logic [31:0] alu_res, val_rm;
   logic        ready;
   logic [31:0] rdata;
   logic [17:0] addr;
   logic [15:0] dq_out, dq_in;
   logic        oe, we_n;
   sram_state_t st;

   mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(WC), .SRAM_AW(18)) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_res(alu_res), .val_rm(val_rm), .ready(ready), .read_data(rdata),
      .sram_addr(addr), .sram_dq_out(dq_out), .sram_dq_oe(oe),
      .sram_dq_in(dq_in), .sram_we_n(we_n), .dbg_state(st)
   );

   // SRAM array model: writes on the clock while we_n is low, async read.
   logic [15:0] mem [0:1023];
   always @(posedge clk) if (!we_n) mem[addr[9:0]] <= dq_out;
   assign dq_in = mem[addr[9:0]];

   // ---------------- WAIT_CYCLES = 1 and = 4 instances ----------------
   logic        r1, r4;
   logic        ready1, ready4, oe1, oe4, we_n1, we_n4;
   logic [31:0] rdata1, rdata4;
   logic [17:0] addr1, addr4;
   logic [15:0] dq_out1, dq_out4, dq_in1, dq_in4;
   sram_state_t st1, st4;
   logic        zero_bit = 1'b0;
   logic [31:0] fixed_addr = 32'd1032;
   logic [31:0] zero_word = 32'd0;

   // Pattern SRAM: each halfword reads as 0xC000 | address.
   assign dq_in1 = 16'hC000 | {4'h0, addr1[11:0]};
   assign dq_in4 = 16'hC000 | {4'h0, addr4[11:0]};

   mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
      .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(zero_bit),
      .alu_res(fixed_addr), .val_rm(zero_word), .ready(ready1), .read_data(rdata1),
      .sram_addr(addr1), .sram_dq_out(dq_out1), .sram_dq_oe(oe1),
      .sram_dq_in(dq_in1), .sram_we_n(we_n1), .dbg_state(st1)
   );

   mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(4), .SRAM_AW(18)) dut4 (
      .clk(clk), .rst(rst), .mem_r_en(r4), .mem_w_en(zero_bit),
      .alu_res(fixed_addr), .val_rm(zero_word), .ready(ready4), .read_data(rdata4),
      .sram_addr(addr4), .sram_dq_out(dq_out4), .sram_dq_oe(oe4),
      .sram_dq_in(dq_in4), .sram_we_n(we_n4), .dbg_state(st4)
   );

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full access on the main DUT, checked cycle by cycle. Starts in the
   // current (IDLE) cycle; returns early at the start of cycle stop_c.
   task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd,
                             input int stop_c);
      logic [31:0] off;
      logic [17:0] hw_lo, hw_hi;
      sram_state_t lo_st, hi_st;
      off   = a - 32'd1024;
      hw_lo = {off[18:2], 1'b0};
      hw_hi = {off[18:2], 1'b1};
      lo_st = w ? WR_LO : RD_LO;
      hi_st = w ? WR_HI : RD_HI;
      mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
      for (int c = 0; c <= 2*WC+1; c++) begin
         if (c == stop_c) return;
         #1;
         if (c == 0) begin
            chk("req_cycle_ready", ready, 0);
            chk("req_cycle_state", st, IDLE);
         end else if (c <= 2*WC) begin
            chk("busy_ready", ready, 0);
            chk("busy_state", st, (c <= WC) ? lo_st : hi_st);
            chk("busy_addr", addr, (c <= WC) ? hw_lo : hw_hi);
            chk("busy_we_n", we_n, !w);
            chk("busy_oe", oe, w);
            if (w) chk("busy_dq_out", dq_out, (c <= WC) ? d[15:0] : d[31:16]);
         end else begin
            chk("done_ready", ready, 1);
            chk("done_state", st, DONE);
            chk("done_we_n", we_n, 1);
            chk("done_read_data", rdata, exp_rd);
            mem_r_en = 0; mem_w_en = 0;
         end
         @(negedge clk);
      end
      #1;
      chk("after_ready", ready, 1);
      chk("after_state", st, IDLE);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int run1, run4, p1, p4;
      rst = 0; mem_r_en = 0; mem_w_en = 0; alu_res = 0; val_rm = 0;
      r1 = 0; r4 = 0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_state", st, IDLE);
      chk("rst_read_data", rdata, 0);
      chk("rst_addr", addr, 0);
      chk("rst_dq_out", dq_out, 0);
      chk("rst_oe", oe, 0);
      chk("rst_we_n", we_n, 1);
      chk("rst_ready", ready, 1);
      @(negedge clk);
      rst = 1;
      @(negedge clk);

      // Store / load round trips
      run_access(0, 1, 32'd1024, 32'hDEADBEEF, 32'h0, 99);
      chk("mem0", {16'h0, mem[0]}, 32'hBEEF);
      chk("mem1", {16'h0, mem[1]}, 32'hDEAD);
      run_access(1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 99);
      run_access(0, 1, 32'd1028, 32'h11223344, 32'hDEADBEEF, 99);
      run_access(0, 1, 32'd2044, 32'hCAFEF00D, 32'hDEADBEEF, 99);
      chk("mem510", {16'h0, mem[510]}, 32'hF00D);
      chk("mem511", {16'h0, mem[511]}, 32'hCAFE);
      run_access(1, 0, 32'd1028, 32'h0, 32'h11223344, 99);
      run_access(1, 0, 32'd2044, 32'h0, 32'hCAFEF00D, 99);
      run_access(1, 0, 32'd1026, 32'h0, 32'hDEADBEEF, 99);

      // Both enables: treated as a store, read_data untouched
      run_access(1, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 99);
      chk("both_mem4", {16'h0, mem[4]}, 32'h5678);
      chk("both_mem5", {16'h0, mem[5]}, 32'h1234);

      // Reset during WR_HI
      run_access(0, 1, 32'd1036, 32'hA5A55A5A, 32'hDEADBEEF, WC + 1);
      #1;
      chk("pre_abort_state", st, WR_HI);
      chk("pre_abort_we_n", we_n, 0);
      #1 rst = 0;
      #1;
      chk("abort_we_n", we_n, 1);
      chk("abort_oe", oe, 0);
      chk("abort_state", st, IDLE);
      chk("abort_read_data", rdata, 0);
      chk("abort_addr", addr, 0);
      chk("abort_ready_req_held", ready, 0);
      mem_w_en = 0;
      #1;
      chk("abort_ready_req_drop", ready, 1);
      @(negedge clk);
      rst = 1;
      @(negedge clk); #1;
      chk("post_abort_state", st, IDLE);
      chk("post_abort_ready", ready, 1);

      // Back-to-back loads on WAIT_CYCLES=1 and =4
      run1 = 0; run4 = 0; p1 = 0; p4 = 0;
      r1 = 1; r4 = 1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (ready1) begin
            chk("w1_low_run", run1, 3);
            chk("w1_done_state", st1, DONE);
            chk("w1_read_data", rdata1, 32'hC005C004);
            p1++; run1 = 0;
         end else run1++;
         if (ready4) begin
            chk("w4_low_run", run4, 9);
            chk("w4_done_state", st4, DONE);
            chk("w4_read_data", rdata4, 32'hC005C004);
            p4++; run4 = 0;
         end else run4++;
         @(negedge clk);
      end
      r1 = 0; r4 = 0;
      chk("w1_done_pulses", p1, 10);
      chk("w4_done_pulses", p4, 4);
      chk("w1_we_n", we_n1, 1);
      chk("w4_oe", oe4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
